// File: rtl/telemetry_arbiter_if.sv
// Bus between telemetry_arbiter, the two telemetry FIFOs and uart_tx.
// master is the arbiter side; slave is the FIFO/UART/system side.
interface telemetry_arbiter_if #(
    parameter int unsigned DWIDTH = 128
);
    logic              en;
    logic [DWIDTH-1:0] fifo_l_dout;
    logic              fifo_l_empty;
    logic              fifo_l_rd_en;
    logic [DWIDTH-1:0] fifo_r_dout;
    logic              fifo_r_empty;
    logic              fifo_r_rd_en;
    logic              uart_start_tx;
    logic [7:0]        uart_tx_din;
    logic              uart_tx_done;
    logic              busy;
    logic              active_ch;
    logic [15:0]       frames_sent;

    modport master (
        input  en, fifo_l_dout, fifo_l_empty, fifo_r_dout, fifo_r_empty, uart_tx_done,
        output fifo_l_rd_en, fifo_r_rd_en, uart_start_tx, uart_tx_din, busy, active_ch,
               frames_sent
    );

    modport slave (
        output en, fifo_l_dout, fifo_l_empty, fifo_r_dout, fifo_r_empty, uart_tx_done,
        input  fifo_l_rd_en, fifo_r_rd_en, uart_start_tx, uart_tx_din, busy, active_ch,
               frames_sent
    );
endinterface

// File: rtl/telemetry_arbiter.sv
// Round-robin arbiter that pops PID records from two FIFOs and streams each one
// to uart_tx as a framed packet: sync, channel, data MSB first, checksum.
module telemetry_arbiter #(
    parameter int unsigned DWIDTH    = 128,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input logic                 clk,
    input logic                 reset,
    telemetry_arbiter_if.master bus
);
    localparam int unsigned     NB        = DWIDTH / 8;
    localparam int unsigned     IdxW      = $clog2(NB + 3);
    localparam logic [IdxW-1:0] LastIdx   = IdxW'(NB + 2);
    localparam logic [IdxW-1:0] FirstData = IdxW'(2);

    typedef enum logic [2:0] {StIdle, StRead, StLatch, StSend, StWait} state_e;

    state_e            state;
    logic [DWIDTH-1:0] shreg;
    logic [IdxW-1:0]   byte_idx;
    logic [7:0]        csum;
    logic              last_grant;
    logic              grant;
    logic              rd_l_q, rd_r_q, start_q, busy_q, active_q;
    logic [7:0]        din_q;
    logic [15:0]       frames_q;
    logic [7:0]        cur_byte;
    logic              is_data;

    // Single non-empty FIFO wins outright; a tie goes opposite the last grant.
    always_comb begin
        grant = ~last_grant;
        if (bus.fifo_l_empty) begin
            grant = 1'b1;
        end else if (bus.fifo_r_empty) begin
            grant = 1'b0;
        end
    end

    always_comb begin
        is_data  = (byte_idx >= FirstData) && (byte_idx != LastIdx);
        cur_byte = shreg[DWIDTH-1 -: 8];
        if (byte_idx == '0) begin
            cur_byte = SYNC_BYTE;
        end else if (byte_idx == IdxW'(1)) begin
            cur_byte = {7'b0, active_q};
        end else if (byte_idx == LastIdx) begin
            cur_byte = csum;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            shreg      <= '0;
            byte_idx   <= '0;
            csum       <= '0;
            last_grant <= 1'b1;
            rd_l_q     <= 1'b0;
            rd_r_q     <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            active_q   <= 1'b0;
            din_q      <= '0;
            frames_q   <= '0;
        end else begin
            rd_l_q  <= 1'b0;
            rd_r_q  <= 1'b0;
            start_q <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (bus.en && (!bus.fifo_l_empty || !bus.fifo_r_empty)) begin
                        active_q <= grant;
                        rd_l_q   <= ~grant;
                        rd_r_q   <= grant;
                        busy_q   <= 1'b1;
                        state    <= StRead;
                    end
                end
                StRead: state <= StLatch;
                StLatch: begin
                    shreg    <= active_q ? bus.fifo_r_dout : bus.fifo_l_dout;
                    byte_idx <= '0;
                    csum     <= {7'b0, active_q};
                    state    <= StSend;
                end
                StSend: begin
                    din_q   <= cur_byte;
                    start_q <= 1'b1;
                    if (is_data) begin
                        csum  <= csum + cur_byte;
                        shreg <= {shreg[DWIDTH-9:0], 8'h00};
                    end
                    state <= StWait;
                end
                StWait: begin
                    if (bus.uart_tx_done) begin
                        byte_idx <= byte_idx + 1'b1;
                        if (byte_idx == LastIdx) begin
                            frames_q   <= frames_q + 16'd1;
                            last_grant <= active_q;
                            busy_q     <= 1'b0;
                            state      <= StIdle;
                        end else begin
                            state <= StSend;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.fifo_l_rd_en  = rd_l_q;
    assign bus.fifo_r_rd_en  = rd_r_q;
    assign bus.uart_start_tx = start_q;
    assign bus.uart_tx_din   = din_q;
    assign bus.busy          = busy_q;
    assign bus.active_ch     = active_q;
    assign bus.frames_sent   = frames_q;
endmodule

// File: tb/tb_telemetry_arbiter.sv
// Scoreboard bench for telemetry_arbiter: FIFO and uart_tx models, expected
// bytes queued by the stimulus and compared by a monitor on every start pulse.
module tb_telemetry_arbiter;
    localparam int unsigned    DW        = 128;
    localparam int             DoneDelay = 20;
    localparam int             Budget    = 5000;
    localparam logic [DW-1:0]  DA        = 128'h0102030405060708090A0B0C0D0E0F10;
    localparam logic [DW-1:0]  DB        = {16{8'h11}};

    logic          clk;
    logic          reset;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            start_cnt = 0;
    int            rd_l_cnt = 0;
    int            rd_r_cnt = 0;
    int            rd_cyc = 0;
    int            done_cnt = 0;
    int            spur_issue = 0;
    int            spur_seen = 0;
    int            spur_rd_issue = 0;
    int            spur_rd_seen = 0;
    logic [7:0]    mon_exp;
    logic [7:0]    exp_q[$];
    logic [DW-1:0] lq[$];
    logic [DW-1:0] rq[$];

    telemetry_arbiter_if #(.DWIDTH(DW)) bus ();

    telemetry_arbiter #(
        .DWIDTH   (DW),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // FIFO models: data appears on dout at the edge that samples rd_en.
    always @(posedge clk) begin
        if (!reset) begin
            if (bus.fifo_l_rd_en || bus.fifo_r_rd_en)
                check("rd_en_exclusive", {31'b0, bus.fifo_l_rd_en & bus.fifo_r_rd_en}, 0);
            if (bus.fifo_l_rd_en) begin
                rd_l_cnt++;
                check("rd_l_nonempty", {31'b0, lq.size() != 0}, 1);
                if (lq.size() != 0) bus.fifo_l_dout <= lq.pop_front();
            end
            if (bus.fifo_r_rd_en) begin
                rd_r_cnt++;
                check("rd_r_nonempty", {31'b0, rq.size() != 0}, 1);
                if (rq.size() != 0) bus.fifo_r_dout <= rq.pop_front();
            end
        end
    end

    // uart_tx model plus empty flags; also injects spurious done pulses on request.
    always @(negedge clk) begin
        bus.uart_tx_done = 1'b0;
        bus.fifo_l_empty = (lq.size() == 0);
        bus.fifo_r_empty = (rq.size() == 0);
        if (reset) begin
            done_cnt = 0;
        end else begin
            if (done_cnt != 0) begin
                done_cnt--;
                if (done_cnt == 0) bus.uart_tx_done = 1'b1;
            end
            if (spur_issue != spur_seen) begin
                spur_seen        = spur_issue;
                bus.uart_tx_done = 1'b1;
            end
            if ((bus.fifo_l_rd_en || bus.fifo_r_rd_en) && spur_rd_issue != spur_rd_seen) begin
                spur_rd_seen     = spur_rd_issue;
                bus.uart_tx_done = 1'b1;
            end
            if (bus.uart_start_tx) done_cnt = DoneDelay;
        end
    end

    // Monitor: every start pulse consumes one expected byte.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.fifo_l_rd_en || bus.fifo_r_rd_en) rd_cyc = cyc;
            if (bus.uart_start_tx) begin
                start_cnt++;
                check("start_has_expected_byte", {31'b0, exp_q.size() != 0}, 1);
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    check("tx_byte", {24'b0, bus.uart_tx_din}, {24'b0, mon_exp});
                    // No test payload or checksum equals A5, so A5 marks a frame start.
                    if (mon_exp == 8'hA5) check("sync_latency", cyc - rd_cyc, 3);
                end
            end
        end
    end

    task automatic push_frame(input logic ch, input logic [DW-1:0] data, input logic [7:0] csum);
        exp_q.push_back(8'hA5);
        exp_q.push_back({7'b0, ch});
        for (int i = 0; i < int'(DW / 8); i++) exp_q.push_back(data[DW-1-8*i -: 8]);
        exp_q.push_back(csum);
    endtask

    task automatic wait_frames(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < Budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_completed_in_time"}, {31'b0, n < Budget}, 1);
    endtask

    task automatic wait_starts(input int target);
        int n = 0;
        while (start_cnt < target && n < Budget) begin
            @(negedge clk);
            n++;
        end
        check("start_count_reached", {31'b0, n < Budget}, 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_l"}, {31'b0, bus.fifo_l_rd_en}, 0);
        check({tag, "_rd_r"}, {31'b0, bus.fifo_r_rd_en}, 0);
        check({tag, "_start"}, {31'b0, bus.uart_start_tx}, 0);
        check({tag, "_din"}, {24'b0, bus.uart_tx_din}, 0);
        check({tag, "_busy"}, {31'b0, bus.busy}, 0);
        check({tag, "_active_ch"}, {31'b0, bus.active_ch}, 0);
        check({tag, "_frames"}, {16'b0, bus.frames_sent}, 0);
    endtask

    initial begin
        int base_s;
        int base_l;
        int base_r;
        reset  = 1'b1;
        bus.en = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b0;

        // Spurious done while idle with empty FIFOs.
        bus.en = 1'b1;
        @(negedge clk);
        spur_issue++;
        repeat (5) @(negedge clk);
        check("spur_idle_no_start", start_cnt, 0);
        check("spur_idle_busy", {31'b0, bus.busy}, 0);

        // Single left frame.
        lq.push_back(DA);
        push_frame(1'b0, DA, 8'h88);
        wait_frames("single");
        check("single_frames", {16'b0, bus.frames_sent}, 1);
        check("single_busy", {31'b0, bus.busy}, 0);
        check("single_active", {31'b0, bus.active_ch}, 0);
        check("single_starts", start_cnt, 19);
        check("single_rd_l", rd_l_cnt, 1);

        // Spurious done during READ must not disturb the frame.
        spur_rd_issue++;
        lq.push_back(DA);
        push_frame(1'b0, DA, 8'h88);
        wait_frames("spur_read");
        check("spur_read_frames", {16'b0, bus.frames_sent}, 2);
        check("spur_read_starts", start_cnt, 38);

        // Round robin from a fresh reset: left wins the first tie.
        bus.en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rr_frames_cleared", {16'b0, bus.frames_sent}, 0);
        base_l = rd_l_cnt;
        base_r = rd_r_cnt;
        lq.push_back(DA);
        lq.push_back(DB);
        rq.push_back(DA);
        rq.push_back(DB);
        push_frame(1'b0, DA, 8'h88);
        push_frame(1'b1, DA, 8'h89);
        push_frame(1'b0, DB, 8'h10);
        push_frame(1'b1, DB, 8'h11);
        bus.en = 1'b1;
        wait_frames("round_robin");
        check("rr_frames", {16'b0, bus.frames_sent}, 4);
        check("rr_rd_l", rd_l_cnt - base_l, 2);
        check("rr_rd_r", rd_r_cnt - base_r, 2);
        check("rr_active", {31'b0, bus.active_ch}, 1);

        // Drop en mid-frame: frame completes, nothing further is popped.
        base_s = start_cnt;
        base_r = rd_r_cnt;
        lq.push_back(DA);
        rq.push_back(DB);
        push_frame(1'b0, DA, 8'h88);
        wait_starts(base_s + 5);
        bus.en = 1'b0;
        wait_frames("en_drop");
        repeat (100) @(negedge clk);
        check("en_drop_starts", start_cnt - base_s, 19);
        check("en_drop_no_rd_r", rd_r_cnt - base_r, 0);
        check("en_drop_busy", {31'b0, bus.busy}, 0);
        check("en_drop_frames", {16'b0, bus.frames_sent}, 5);
        push_frame(1'b1, DB, 8'h11);
        bus.en = 1'b1;
        wait_frames("en_resume");
        check("en_resume_frames", {16'b0, bus.frames_sent}, 6);

        // Reset during byte 10 of a left frame.
        base_s = start_cnt;
        lq.push_back(DB);
        rq.push_back(DA);
        push_frame(1'b0, DB, 8'h10);
        wait_starts(base_s + 10);
        reset = 1'b1;
        #1;
        check_outputs_zero("mid_reset");
        exp_q.delete();
        lq.push_back(DA);
        push_frame(1'b0, DA, 8'h88);
        push_frame(1'b1, DA, 8'h89);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_frames("after_reset");
        check("after_reset_frames", {16'b0, bus.frames_sent}, 2);

        // Counter wrap.
        @(negedge clk);
        force dut.frames_q = 16'hFFFF;
        @(negedge clk);
        release dut.frames_q;
        lq.push_back(DA);
        push_frame(1'b0, DA, 8'h88);
        wait_frames("wrap");
        check("wrap_frames", {16'b0, bus.frames_sent}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
